// File: rtl/readout_arbiter.sv
// readout_arbiter: round-robin grant of full banks and serial framing onto one readout link.
// Optional macro READOUT_PARITY_EN appends an even-parity bit over the DATA field.
module readout_arbiter #(
  parameter int NCH = 4,
  parameter int ID_W = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 3,
  parameter int TIME_W = 32,
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          req,
  input  logic [NCH*ADDR_W-1:0]   idx_final,
  input  logic [NCH*TIME_W-1:0]   event_time,
  input  logic [DATA_W-1:0]       data_in,
  output logic [NCH-1:0]          grant,
  output logic [NCH-1:0]          done,
  output logic                    re,
  output logic [ADDR_W-1:0]       addr_out,
  output logic                    serial_out,
  output logic                    frame_valid,
  output logic                    busy,
  output logic [2:0]              state
);
  localparam int M1 = TIME_W > ADDR_W ? TIME_W : ADDR_W;
  localparam int M2 = M1 > 8 ? M1 : 8;
  localparam int MW = M2 > DATA_W ? M2 : DATA_W;
  localparam int CW = $clog2(MW);
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_SYNC, S_ID, S_TIME, S_COUNT, S_DATA, S_REL} st_t;
  st_t st, nxt;
  logic [ID_W-1:0] ptr, id, win, c;
  logic [ADDR_W-1:0] idx, addr_q;
  logic [TIME_W-1:0] tm;
  logic [MW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [ADDR_W:0] ld;
  logic fv, last, more, pend;
`ifdef READOUT_PARITY_EN
  logic par;
`else
  assign pend = 1'b0;
`endif
  always_comb begin
    win = ptr;
    c = ptr;
    for (int i = NCH; i >= 1; i--) begin
      c = ID_W'((32'(ptr) + i) % NCH);
      if (req[c]) win = c;
    end
  end
  // ld counts samples loaded so far; it is also the address of the next read
  assign last = cnt == '0;
  assign more = ld <= {1'b0, idx};
  assign re = (st == S_COUNT || st == S_DATA) && cnt == CW'(1) && more;
  assign addr_out = re ? ld[ADDR_W-1:0] : addr_q;
  assign done = st == S_REL && !pend ? grant : '0;
  assign serial_out = sh[MW-1];
  assign frame_valid = fv;
  assign busy = st != S_IDLE;
  assign state = st;
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= S_IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:  nxt = |req ? S_ARB : S_IDLE;
      S_ARB:   nxt = |req ? S_SYNC : S_IDLE;
      S_SYNC:  nxt = last ? S_ID : S_SYNC;
      S_ID:    nxt = last ? S_TIME : S_ID;
      S_TIME:  nxt = last ? S_COUNT : S_TIME;
      S_COUNT: nxt = last ? S_DATA : S_COUNT;
      S_DATA:  nxt = last && !more ? S_REL : S_DATA;
      S_REL:   nxt = pend ? S_REL : S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr <= ID_W'(NCH - 1);
      id <= '0;
      idx <= '0;
      tm <= '0;
      sh <= '0;
      cnt <= '0;
      ld <= '0;
      addr_q <= '0;
      fv <= 1'b0;
      grant <= '0;
`ifdef READOUT_PARITY_EN
      par <= 1'b0;
      pend <= 1'b0;
`endif
    end else begin
      addr_q <= addr_out;
      sh <= sh << 1;
      cnt <= cnt - CW'(1);
`ifdef READOUT_PARITY_EN
      if (st == S_DATA) par <= par ^ sh[MW-1];
`endif
      case (st)
        S_ARB: if (|req) begin
          grant <= NCH'(1) << win;
          id <= win;
          ptr <= win;
          idx <= idx_final[win*ADDR_W +: ADDR_W];
          tm <= event_time[win*TIME_W +: TIME_W];
          ld <= '0;
          sh <= MW'(SYNC) << (MW - 8);
          cnt <= CW'(7);
          fv <= 1'b1;
`ifdef READOUT_PARITY_EN
          par <= 1'b0;
`endif
        end
        S_SYNC: if (last) begin
          sh <= MW'(id) << (MW - ID_W);
          cnt <= CW'(ID_W - 1);
        end
        S_ID: if (last) begin
          sh <= MW'(tm) << (MW - TIME_W);
          cnt <= CW'(TIME_W - 1);
        end
        S_TIME: if (last) begin
          sh <= MW'(idx) << (MW - ADDR_W);
          cnt <= CW'(ADDR_W - 1);
        end
        S_COUNT, S_DATA: if (last) begin
          if (more) begin
            sh <= MW'(data_in) << (MW - DATA_W);
            cnt <= CW'(DATA_W - 1);
            ld <= ld + (ADDR_W+1)'(1);
          end else begin
`ifdef READOUT_PARITY_EN
            sh <= MW'(par ^ sh[MW-1]) << (MW - 1);
            pend <= 1'b1;
`else
            fv <= 1'b0;
`endif
          end
        end
        S_REL: begin
          fv <= 1'b0;
          sh <= '0;
          if (!pend) grant <= '0;
`ifdef READOUT_PARITY_EN
          pend <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_readout_arbiter.sv
// tb_readout_arbiter: table vectors plus frame/address scoreboard for readout_arbiter.
module tb_readout_arbiter;
`ifdef READOUT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  typedef struct {logic [3:0] rq; int ch; logic [7:0] idx; logic [31:0] tm; logic [3:0] gnt; int len;} vec_t;
  typedef struct {int ch; int len;} fr_t;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req;
  logic [31:0] idx_final;
  logic [127:0] event_time;
  logic [2:0] data_in;
  logic [3:0] grant, done;
  logic re, serial_out, frame_valid, busy;
  logic [7:0] addr_out;
  logic [2:0] state;
  logic [2:0] mem [4][256];
  logic rd_pend;
  logic [2:0] rd_val;
  logic bq[$];
  int aq[$];
  fr_t fq[$];
  int nchk = 0, nfail = 0, cyc = 0, ndone = 0, last_len = 0, last_done = -1;
  bit b2b = 0;
  readout_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .idx_final(idx_final), .event_time(event_time),
    .data_in(data_in), .grant(grant), .done(done), .re(re), .addr_out(addr_out),
    .serial_out(serial_out), .frame_valid(frame_valid), .busy(busy), .state(state)
  );
  always #5 clk = ~clk;
  function automatic int gidx(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction
  // memory read port: data valid exactly the cycle after re, garbage otherwise
  always @(negedge clk) begin
    rd_pend <= re;
    rd_val <= mem[gidx(grant)][addr_out];
  end
  always @(posedge clk) data_in <= rd_pend ? rd_val : 3'($urandom);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic push_frame(input int ch, input int ix, input logic [31:0] tm);
    logic [7:0] sy, iv;
    logic [1:0] cv;
    logic [2:0] d;
    logic p;
    int n;
    sy = 8'hA5;
    iv = 8'(ix);
    cv = 2'(ch);
    p = 1'b0;
    n = 0;
    for (int i = 7; i >= 0; i--) begin bq.push_back(sy[i]); n++; end
    for (int i = 1; i >= 0; i--) begin bq.push_back(cv[i]); n++; end
    for (int i = 31; i >= 0; i--) begin bq.push_back(tm[i]); n++; end
    for (int i = 7; i >= 0; i--) begin bq.push_back(iv[i]); n++; end
    for (int k = 0; k <= ix; k++) begin
      d = mem[ch][k];
      aq.push_back(k);
      for (int i = 2; i >= 0; i--) begin bq.push_back(d[i]); p ^= d[i]; n++; end
    end
`ifdef READOUT_PARITY_EN
    bq.push_back(p);
    n++;
`endif
    fq.push_back('{ch, n});
  endtask
  task automatic monitor();
    int n = 0, nmis = 0, first = 0;
    fr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        n = 0;
        nmis = 0;
      end else begin
        if (re) begin
          chk("re_expected", aq.size() > 0, 1);
          if (aq.size() > 0) chk("re_addr", addr_out, aq.pop_front());
        end
        if (frame_valid) begin
          if (n == 0) begin
            first = cyc;
            if (b2b && last_done >= 0) chk("gap_cycles", cyc - last_done, 3);
          end
          if (bq.size() > 0) begin
            if (serial_out !== bq.pop_front()) nmis++;
          end else nmis++;
          n++;
        end
        if (done != 0) begin
          chk("frame_expected", fq.size() > 0, 1);
          if (fq.size() > 0) begin
            e = fq.pop_front();
            chk("done_onehot", done, 4'(1) << e.ch);
            chk("grant_at_done", grant, 4'(1) << e.ch);
            chk("frame_bit_errors", nmis, 0);
            chk("frame_len", n, e.len);
            chk("frame_span", cyc - first, e.len);
            while (n < e.len && bq.size() > 0) begin void'(bq.pop_front()); n++; end
          end
          last_len = n;
          last_done = cyc;
          ndone++;
          n = 0;
          nmis = 0;
        end
      end
    end
  endtask
  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (ndone < target && t < budget) begin @(negedge clk); t++; end
    chk("done_timeout", ndone >= target, 1);
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget);
    int t = 0;
    while (state !== s && t < budget) begin @(negedge clk); t++; end
    chk("state_timeout", state, s);
  endtask
  task automatic wait_grant(input logic [3:0] g);
    int t = 0;
    while (grant == 0 && t < 50) begin @(negedge clk); t++; end
    chk("grant", grant, g);
  endtask
  task automatic check_quiet(input string nm);
    chk({nm, "_grant"}, grant, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_re"}, re, 0);
    chk({nm, "_addr"}, addr_out, 0);
    chk({nm, "_serial"}, serial_out, 0);
    chk({nm, "_valid"}, frame_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_state"}, state, 0);
  endtask
  task automatic pulse_reset(input string nm);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_quiet(nm);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask
  task automatic set_ch(input int ch, input logic [7:0] ix, input logic [31:0] tm);
    idx_final[ch*8 +: 8] = ix;
    event_time[ch*32 +: 32] = tm;
  endtask
  task automatic run_vec(input vec_t v);
    int nd;
    nd = ndone;
    set_ch(v.ch, v.idx, v.tm);
    push_frame(v.ch, int'(v.idx), v.tm);
    req = v.rq;
    wait_grant(v.gnt);
    chk("busy_in_frame", busy, 1);
    wait_done(nd + 1, 2000);
    req = 4'b0000;
    chk("vec_len", last_len, v.len + PB);
    repeat (3) @(negedge clk);
    chk("vec_idle", state, 0);
  endtask
  initial begin
    vec_t tv[5];
    int nd;
    reset = 1'b1;
    req = '0;
    idx_final = '0;
    event_time = '0;
    for (int c = 0; c < 4; c++) for (int k = 0; k < 256; k++) mem[c][k] = 3'($urandom);
    mem[0][0] = 3'b101; mem[0][1] = 3'b010; mem[0][2] = 3'b111;
    mem[1][0] = 3'b001; mem[1][1] = 3'b001;
    tv[0] = '{4'b0001, 0, 8'd2,   32'h12345678, 4'b0001, 59};
    tv[1] = '{4'b0100, 2, 8'd0,   32'hDEADBEEF, 4'b0100, 53};
    tv[2] = '{4'b0100, 2, 8'hFF,  32'h00000000, 4'b0100, 818};
    tv[3] = '{4'b1000, 3, 8'd5,   32'hFFFFFFFF, 4'b1000, 68};
    tv[4] = '{4'b0010, 1, 8'd1,   32'h00000001, 4'b0010, 56};
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check_quiet("reset");
    #2 reset = 1'b0;
    @(negedge clk);
    check_quiet("idle");
    for (int i = 0; i < 5; i++) run_vec(tv[i]);
    // round robin with all channels requesting back to back
    pulse_reset("rr_reset");
    for (int c = 0; c < 4; c++) set_ch(c, 8'(c + 1), 32'hA0000000 + c);
    for (int c = 0; c < 5; c++) push_frame(c % 4, (c % 4) + 1, 32'hA0000000 + (c % 4));
    b2b = 1;
    last_done = -1;
    nd = ndone;
    req = 4'b1111;
    wait_done(nd + 5, 2000);
    req = 4'b0000;
    b2b = 0;
    repeat (3) @(negedge clk);
    // reset in the middle of the TIME field aborts the frame without done
    set_ch(0, 8'd3, 32'h55AA55AA);
    nd = ndone;
    req = 4'b0001;
    wait_state(3'd4, 100);
    repeat (5) @(negedge clk);
    req = 4'b0000;
    pulse_reset("abort");
    chk("abort_no_done", ndone, nd);
    set_ch(1, 8'd1, 32'h0BADF00D);
    push_frame(1, 1, 32'h0BADF00D);
    req = 4'b0010;
    wait_grant(4'b0010);
    wait_done(nd + 1, 500);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    // request withdrawn during DATA still completes the frame
    set_ch(1, 8'd1, 32'h13579BDF);
    push_frame(1, 1, 32'h13579BDF);
    nd = ndone;
    req = 4'b0010;
    wait_state(3'd6, 100);
    req = 4'b0000;
    wait_done(nd + 1, 500);
    chk("drop_len", last_len, 56 + PB);
    repeat (3) @(negedge clk);
    chk("final_state", state, 0);
    chk("final_busy", busy, 0);
    chk("bits_drained", bq.size(), 0);
    chk("addrs_drained", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
